// File: rtl/drm_uip_stream_adapter.sv
// Activator-side endpoint of the DRM per-user-IP AXI4-Stream link.
// Optional counters: define DRM_UIP_ADAPTER_STATS_EN to add stat_* outputs.
module drm_uip_stream_adapter #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 20
) (
  input  logic              drm_aclk,
  input  logic              drm_arst,
  output logic              s_tready,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              m_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              act_dat_o,
  output logic              act_we_o,
  output logic [1:0]        act_adr_o,
  output logic              act_cyc_o,
  output logic              act_cs_o,
  input  logic              act_dat_i,
  input  logic              act_sta_i,
  input  logic              act_intr_i,
  input  logic              act_ack_i,
  output logic              link_lost
`ifdef DRM_UIP_ADAPTER_STATS_EN
  ,
  output logic [31:0]       stat_in_beats,
  output logic [15:0]       stat_overwrites
`endif
);

  typedef enum logic [1:0] {
    SK_EMPTY,
    SK_ONE,
    SK_TWO
  } skid_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  skid_t             sk_q, sk_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [DATA_W-1:0] samp;
  logic [CNT_W-1:0]  wdog_q;
  logic              accept;
  logic              lost_nxt;
  logic              ovw;

  assign accept   = s_tvalid & s_tready;
  assign lost_nxt = !accept && (wdog_q == TMO);
  assign samp     = {{(DATA_W-4){1'b0}},
                     act_ack_i, act_intr_i,
                     act_sta_i, act_dat_i};
  assign m_tvalid = (sk_q != SK_EMPTY);
  assign m_tdata  = head_q;
  assign ovw      = (sk_q == SK_TWO) && !m_tready;

  generate
    if (DATA_W > 6) begin : g_rsvd
      logic unused_rsvd;
      assign unused_rsvd = ^s_tdata[DATA_W-1:6];
    end
  endgenerate

  // Head is only replaced once the sink has taken it.
  always_comb begin
    sk_d   = sk_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (sk_q)
      SK_EMPTY: begin
        head_d = samp;
        sk_d   = SK_ONE;
      end
      SK_ONE: begin
        if (m_tready) begin
          head_d = samp;
        end else begin
          tail_d = samp;
          sk_d   = SK_TWO;
        end
      end
      SK_TWO: begin
        if (m_tready) head_d = tail_q;
        tail_d = samp;
      end
      default: sk_d = SK_EMPTY;
    endcase
  end

  always_ff @(posedge drm_aclk) begin
    if (drm_arst) begin
      sk_q   <= SK_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      sk_q   <= sk_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge drm_aclk) begin
    if (drm_arst) begin
      s_tready  <= 1'b0;
      act_dat_o <= 1'b0;
      act_we_o  <= 1'b0;
      act_adr_o <= 2'b00;
      act_cyc_o <= 1'b0;
      act_cs_o  <= 1'b0;
      wdog_q    <= '0;
      link_lost <= 1'b0;
    end else begin
      s_tready  <= 1'b1;
      link_lost <= lost_nxt;
      if (accept) begin
        {act_cs_o, act_cyc_o, act_adr_o,
         act_we_o, act_dat_o} <= s_tdata[5:0];
      end else if (lost_nxt) begin
        act_cyc_o <= 1'b0;
        act_cs_o  <= 1'b0;
        act_we_o  <= 1'b0;
      end
      if (accept)
        wdog_q <= '0;
      else if (wdog_q != TMO)
        wdog_q <= wdog_q + 1'b1;
    end
  end

`ifdef DRM_UIP_ADAPTER_STATS_EN
  always_ff @(posedge drm_aclk) begin
    if (drm_arst) begin
      stat_in_beats   <= '0;
      stat_overwrites <= '0;
    end else begin
      if (accept) stat_in_beats <= stat_in_beats + 1'b1;
      if (ovw) stat_overwrites <= stat_overwrites + 1'b1;
    end
  end
`else
  logic unused_ovw;
  assign unused_ovw = ovw;
`endif

endmodule

// File: tb/tb_drm_uip_stream_adapter.sv
// Directed bench for drm_uip_stream_adapter.
// Uses TIMEOUT_CYCLES=8 to exercise the link watchdog.
module tb_drm_uip_stream_adapter;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic          s_tready, s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          m_tready, m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          a_dat, a_we, a_cyc, a_cs;
  logic [1:0]    a_adr;
  logic [3:0]    ain;
  logic          link_lost;
`ifdef DRM_UIP_ADAPTER_STATS_EN
  logic [31:0]   st_in;
  logic [15:0]   st_ov;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  drm_uip_stream_adapter #(
    .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(20)
  ) dut (
    .drm_aclk  (clk),
    .drm_arst  (arst),
    .s_tready  (s_tready),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .m_tready  (m_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .act_dat_o (a_dat),
    .act_we_o  (a_we),
    .act_adr_o (a_adr),
    .act_cyc_o (a_cyc),
    .act_cs_o  (a_cs),
    .act_dat_i (ain[0]),
    .act_sta_i (ain[1]),
    .act_intr_i(ain[2]),
    .act_ack_i (ain[3]),
    .link_lost (link_lost)
`ifdef DRM_UIP_ADAPTER_STATS_EN
    ,
    .stat_in_beats  (st_in),
    .stat_overwrites(st_ov)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] acts();
    return {a_cs, a_cyc, a_adr, a_we, a_dat};
  endfunction

  initial begin
    arst = 1'b1; s_tvalid = 1'b0; s_tdata = '0;
    m_tready = 1'b1; ain = 4'h0;
    step(); step();
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_lost", 32'(link_lost), 32'd0);
    chk("rst_acts", 32'(acts()), 32'd0);

    arst = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hFFFF_FFC0 | 32'h35;
    step();
    chk("tready_up", 32'(s_tready), 32'd1);
    chk("no_early_acc", 32'(acts()), 32'd0);
    step();
    s_tvalid = 1'b0;
    chk("in_cs", 32'(a_cs), 32'd1);
    chk("in_cyc", 32'(a_cyc), 32'd1);
    chk("in_adr", 32'(a_adr), 32'd1);
    chk("in_we", 32'(a_we), 32'd0);
    chk("in_dat", 32'(a_dat), 32'd1);

    ain = 4'b1010;
    step();
    chk("out_valid", 32'(m_tvalid), 32'd1);
    chk("out_A", m_tdata, 32'h0000_000A);
    ain = 4'b0101;
    step();
    chk("out_5", m_tdata, 32'h5);

    // watchdog: last accept on next edge, lost 9 edges later
    s_tvalid = 1'b1; s_tdata = 32'h35;
    step();
    s_tvalid = 1'b0;
    for (int i = 1; i <= TO; i++) step();
    chk("wd_pre", 32'(link_lost), 32'd0);
    chk("wd_pre_cs", 32'(a_cs), 32'd1);
    step();
    chk("wd_lost", 32'(link_lost), 32'd1);
    chk("wd_cyc", 32'(a_cyc), 32'd0);
    chk("wd_cs", 32'(a_cs), 32'd0);
    chk("wd_adr", 32'(a_adr), 32'd1);
    chk("wd_dat", 32'(a_dat), 32'd1);
    step();
    chk("wd_hold", 32'(link_lost), 32'd1);

    s_tvalid = 1'b1; s_tdata = 32'h30;
    step();
    s_tvalid = 1'b0;
    chk("rec_lost", 32'(link_lost), 32'd0);
    chk("rec_acts", 32'(acts()), 32'h30);
    for (int i = 1; i <= TO; i++) step();
    chk("rec_pre", 32'(link_lost), 32'd0);
    // accept on the edge that would reach timeout
    s_tvalid = 1'b1; s_tdata = 32'h3E;
    step();
    s_tvalid = 1'b0;
    chk("race_lost", 32'(link_lost), 32'd0);
    chk("race_acts", 32'(acts()), 32'h3E);
    for (int i = 1; i <= TO; i++) step();
    chk("race_pre", 32'(link_lost), 32'd0);
    step();
    chk("race_lost2", 32'(link_lost), 32'd1);
    chk("race_forced", 32'(acts()), 32'h0C);

    // skid stall from empty
    arst = 1'b1;
    step();
    arst = 1'b0; m_tready = 1'b0; ain = 4'h1;
    step();
    chk("stall_v", 32'(m_tvalid), 32'd1);
    chk("stall_h1", m_tdata, 32'h1);
    for (int v = 2; v <= 5; v++) begin
      ain = 4'(v);
      step();
      chk("stall_hold", m_tdata, 32'h1);
    end
`ifdef DRM_UIP_ADAPTER_STATS_EN
    chk("stat_ov", 32'(st_ov), 32'd3);
`endif
    m_tready = 1'b1; ain = 4'h6;
    step();
    chk("drain_5", m_tdata, 32'h5);
    step();
    chk("drain_live", m_tdata, 32'h6);

    // reset while two entries held
    s_tvalid = 1'b1; s_tdata = 32'h35;
    m_tready = 1'b0; ain = 4'h9;
    step();
    s_tvalid = 1'b0; ain = 4'h7;
    step();
    chk("pre_rst_acts", 32'(acts()), 32'h35);
    arst = 1'b1;
    step();
    chk("mr_valid", 32'(m_tvalid), 32'd0);
    chk("mr_acts", 32'(acts()), 32'd0);
    chk("mr_tdata", m_tdata, 32'd0);
    chk("mr_tready", 32'(s_tready), 32'd0);
    arst = 1'b0; ain = 4'hC;
    step();
    chk("mr_fresh_v", 32'(m_tvalid), 32'd1);
    chk("mr_fresh", m_tdata, 32'hC);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/drm_uip_stream_adapter.md
Name: drm_uip_stream_adapter

Overview:
- Activator-side endpoint of the per-user-IP AXI4-Stream link from the DRM controller top level.
- Consumes drm_to_uipN beats and unpacks them into registered DRM bus strobes for the activator.
- Packs activator status bits into uipN_to_drm beats through a 2-entry skid buffer.
- Runs a link watchdog that forces the activator bus idle when controller beats stop arriving.

Parameters:
- DATA_W, 32, stream tdata width in both directions. Must be >= 6.
- TIMEOUT_CYCLES, 1024, cycles without an accepted inbound beat before link_lost asserts. Range 2..2^20.
- CNT_W, 20, watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- drm_aclk  in  1  single clock for all logic
- drm_arst  in  1  reset; synchronous, active-high
- s_tready  out  1  inbound ready (to drm_to_uipN_tready)
- s_tvalid  in  1  inbound valid
- s_tdata  in  DATA_W  inbound beat: [0]dat [1]we [3:2]adr [4]cyc [5]cs, rest reserved
- m_tready  in  1  outbound ready (from uipN_to_drm_tready)
- m_tvalid  out  1  outbound valid
- m_tdata  out  DATA_W  outbound beat: [0]dat [1]sta [2]intr [3]ack, rest 0
- act_dat_o  out  1  DRM bus data to activator
- act_we_o  out  1  write enable to activator
- act_adr_o  out  2  address to activator
- act_cyc_o  out  1  cycle strobe to activator
- act_cs_o  out  1  chip select to activator
- act_dat_i  in  1  activator data
- act_sta_i  in  1  activator status
- act_intr_i  in  1  activator interrupt
- act_ack_i  in  1  activator acknowledge
- link_lost  out  1  watchdog expired

Behaviour:
- Reset: while drm_arst=1 at a clock edge:
  - all act_*_o, m_tvalid, link_lost, s_tready = 0; m_tdata = 0;
  - skid count = 0; watchdog = 0.
  - Reset asserted mid-transfer drops any in-flight beat; nothing is replayed.
- Inbound:
  - s_tready = 1 in every non-reset cycle (registered, so it is 1 from the first cycle after reset).
  - Accept = s_tvalid & s_tready. On accept, s_tdata[5:0] is registered onto act_*_o.
  - Latency is 1 cycle. act_*_o hold their value between accepts.
  - Reserved bits [DATA_W-1:6] are ignored.
- Outbound sampling:
  - Every non-reset cycle, sample S = {act_ack_i, act_intr_i, act_sta_i, act_dat_i}, zero-extended to DATA_W.
- Outbound skid buffer, 2 entries (head, tail); count ∈ {0,1,2}; m_tvalid = (count != 0); m_tdata = head.
  - count 0: push S into head; count becomes 1.
  - count 1, m_tready=1: head <= S; count stays 1.
  - count 1, m_tready=0: tail <= S; count becomes 2.
  - count 2, m_tready=1: head <= tail, tail <= S; count stays 2.
  - count 2, m_tready=0: tail <= S (overwrite, latest state wins); count stays 2. Head is never overwritten while valid, so AXI-S stability holds.
- Watchdog:
  - Cleared to 0 on accept.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - link_lost registered = (watchdog == TIMEOUT_CYCLES).
  - While link_lost=1: act_cyc_o, act_cs_o, act_we_o forced 0. act_dat_o and act_adr_o hold their last value.
  - Accept while link_lost=1: link_lost falls and the new beat drives act_*_o on the same next edge.
  - Accept in the same cycle the counter would reach TIMEOUT_CYCLES: accept wins; link_lost stays 0.

Optional Feature:
- Macro: DRM_UIP_ADAPTER_STATS_EN.
- Defined, adds two outputs:
  - stat_in_beats (32): count of accepted inbound beats.
  - stat_overwrites (16): count of count-2/m_tready=0 tail overwrites.
  - Both reset to 0, wrap modulo 2^width, and are not reset by link_lost.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, s_tvalid=1, s_tdata=0x35 -> s_tready=1 one cycle after reset drops; next cycle act_cs_o=1, act_cyc_o=1, act_adr_o=2'b01, act_we_o=0, act_dat_o=1.
- act_{ack,intr,sta,dat}_i=4'b1010, m_tready=1 -> m_tvalid=1 and m_tdata=0x0000000A one cycle later; m_tdata tracks input changes with 1-cycle latency.
- m_tready=0 for 5 cycles while inputs step 0x1,0x2,0x3,0x4,0x5, then m_tready=1 -> head held at 0x1 throughout; next beats 0x5, then the live sample; stat_overwrites=3 when STATS_EN is defined.
- TIMEOUT_CYCLES=8, s_tvalid held 0 after a beat with cyc=cs=1 -> link_lost=1 exactly 9 cycles after the last accept; act_cyc_o=act_cs_o=0; act_adr_o unchanged.
- While link_lost=1, one beat s_tdata=0x30 -> next cycle link_lost=0, act_cs_o=1, act_cyc_o=1; watchdog restarts from 0.
- Assert drm_arst for 1 cycle while count=2 -> m_tvalid=0 and all act_*_o=0 next cycle; no stale head is presented afterwards.
